// File: rtl/mont_accum_scheduler_pkg.sv
// Shared types and sizing helpers for the Montgomery accumulator scheduler.
package mont_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

    localparam int DEF_REGISTER_SIZE = 32;
    localparam int DEF_BITS_IN_NUM   = 4096;
    localparam int DEF_EXP_BITS      = 2048;
    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_FLUSH_CYCLES  = 2;

    localparam int EXP_WORDS     = DEF_EXP_BITS / DEF_REGISTER_SIZE;
    localparam int RESULT_BLOCKS = DEF_BITS_IN_NUM / DEF_REGISTER_SIZE;

    // Width of a counter that must hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // Width of an index selecting one of n items.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mont_accum_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer.
module rr_arbiter
    import mont_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [idx_w(NUM_REQ)-1:0]   idx_o
);
    localparam int IW = idx_w(NUM_REQ);

    logic found_s;
    int   j_s;

    // Scan requesters starting from the pointer, wrapping around.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        j_s     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j_s = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_s && req_i[IW'(j_s)]) begin
                found_s           = 1'b1;
                grant_o[IW'(j_s)] = 1'b1;
                idx_o             = IW'(j_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mont_accum_scheduler.sv
// Time-shares one mont_accumulator between requesters: grant, flush, feed exponent
// bits serially, then forward the result blocks back to the granted requester.
module mont_accum_scheduler
    import mont_sched_pkg::*;
#(
    parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
    parameter int BITS_IN_NUM   = DEF_BITS_IN_NUM,
    parameter int EXP_BITS      = DEF_EXP_BITS,
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_in,
    output logic [NUM_REQ-1:0]       grant_out,
    input  logic [REGISTER_SIZE-1:0] exp_word_in,
    input  logic                     exp_word_valid_in,
    output logic                     exp_word_ready_out,
    output logic                     acc_rst_out,
    output logic                     acc_valid_out,
    output logic                     acc_n_bit_out,
    input  logic                     acc_consumed_n_in,
    input  logic                     acc_valid_in,
    input  logic [REGISTER_SIZE-1:0] acc_data_in,
    output logic [REGISTER_SIZE-1:0] result_data_out,
    output logic                     result_valid_out,
    output logic                     result_last_out,
    output logic [NUM_REQ-1:0]       done_out,
    output logic                     busy_out,
    output logic                     underrun_out
);
    localparam int N_WORDS  = EXP_BITS / REGISTER_SIZE;
    localparam int N_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int BW = idx_w(REGISTER_SIZE);
    localparam int DW = cnt_w(EXP_BITS);
    localparam int WW = cnt_w(N_WORDS);
    localparam int KW = cnt_w(N_BLOCKS);
    localparam int FW = cnt_w(FLUSH_CYCLES);
    localparam int PW = idx_w(NUM_REQ);

    sched_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [PW-1:0]            gidx_q, gidx_d, ptr_q, ptr_d;
    logic [FW-1:0]            flush_cnt_q, flush_cnt_d;
    logic [REGISTER_SIZE-1:0] cur_word_q, cur_word_d, next_word_q, next_word_d;
    logic                     cur_valid_q, cur_valid_d, next_valid_q, next_valid_d;
    logic [BW-1:0]            bit_idx_q, bit_idx_d;
    logic [DW-1:0]            bits_done_q, bits_done_d;
    logic [WW-1:0]            words_q, words_d;
    logic [KW-1:0]            blk_cnt_q, blk_cnt_d;
    logic [REGISTER_SIZE-1:0] res_data_q, res_data_d;
    logic                     res_valid_q, res_valid_d, res_last_q, res_last_d;
    logic                     underrun_q, underrun_d;

    logic [NUM_REQ-1:0] arb_grant_s;
    logic [PW-1:0]      arb_idx_s;
    logic               ready_s, accept_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_in),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s)
    );

    // State-decoded accumulator controls, word handshake and done pulse.
    always_comb begin
        acc_rst_out   = 1'b0;
        acc_valid_out = 1'b0;
        ready_s       = 1'b0;
        done_out      = '0;
        case (state_q)
            ST_IDLE, ST_FLUSH: acc_rst_out = 1'b1;
            ST_LOAD:           ready_s = 1'b1;
            ST_RUN: begin
                acc_valid_out = 1'b1;
                ready_s       = !next_valid_q && (words_q < WW'(N_WORDS));
            end
            ST_DRAIN:          acc_valid_out = 1'b1;
            ST_DONE: begin
                acc_rst_out = 1'b1;
                done_out    = grant_q;
            end
            default:           acc_rst_out = 1'b1;
        endcase
    end

    assign accept_s           = exp_word_valid_in && ready_s;
    assign exp_word_ready_out = ready_s;
    assign acc_n_bit_out      = (state_q == ST_RUN) && cur_valid_q && cur_word_q[bit_idx_q];
    assign grant_out          = grant_q;
    assign result_data_out    = res_data_q;
    assign result_valid_out   = res_valid_q;
    assign result_last_out    = res_last_q;
    assign busy_out           = (state_q != ST_IDLE);
    assign underrun_out       = underrun_q;

    // Next-state logic for the job sequence and the bit/word/block bookkeeping.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        ptr_d        = ptr_q;
        flush_cnt_d  = flush_cnt_q;
        cur_word_d   = cur_word_q;
        cur_valid_d  = cur_valid_q;
        next_word_d  = next_word_q;
        next_valid_d = next_valid_q;
        bit_idx_d    = bit_idx_q;
        bits_done_d  = bits_done_q;
        words_d      = words_q;
        blk_cnt_d    = blk_cnt_q;
        res_data_d   = res_data_q;
        res_valid_d  = 1'b0;
        res_last_d   = 1'b0;
        underrun_d   = underrun_q;
        case (state_q)
            ST_IDLE: begin
                if (req_in != '0) begin
                    grant_d      = arb_grant_s;
                    gidx_d       = arb_idx_s;
                    flush_cnt_d  = '0;
                    cur_valid_d  = 1'b0;
                    next_valid_d = 1'b0;
                    bit_idx_d    = '0;
                    bits_done_d  = '0;
                    words_d      = '0;
                    blk_cnt_d    = '0;
                    state_d      = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    cur_word_d  = exp_word_in;
                    cur_valid_d = 1'b1;
                    bit_idx_d   = '0;
                    words_d     = WW'(1);
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                // While starved (cur_valid_q low) consumed pulses do not advance the stream.
                if (acc_consumed_n_in && cur_valid_q) begin
                    bits_done_d = bits_done_q + DW'(1);
                    if (bits_done_q == DW'(EXP_BITS - 1)) begin
                        state_d = ST_DRAIN;
                    end else if (bit_idx_q == BW'(REGISTER_SIZE - 1)) begin
                        bit_idx_d = '0;
                        if (next_valid_q) begin
                            cur_word_d   = next_word_q;
                            next_valid_d = 1'b0;
                        end else if (accept_s) begin
                            cur_word_d = exp_word_in;
                            words_d    = words_q + WW'(1);
                        end else begin
                            cur_valid_d = 1'b0;
                            underrun_d  = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        if (accept_s) begin
                            next_word_d  = exp_word_in;
                            next_valid_d = 1'b1;
                            words_d      = words_q + WW'(1);
                        end else begin
                            next_valid_d = next_valid_q;
                        end
                    end
                end else if (accept_s) begin
                    words_d = words_q + WW'(1);
                    if (!cur_valid_q) begin
                        cur_word_d  = exp_word_in;
                        cur_valid_d = 1'b1;
                        bit_idx_d   = '0;
                    end else begin
                        next_word_d  = exp_word_in;
                        next_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (acc_valid_in) begin
                    res_data_d  = acc_data_in;
                    res_valid_d = 1'b1;
                    blk_cnt_d   = blk_cnt_q + KW'(1);
                    if (blk_cnt_q == KW'(N_BLOCKS - 1)) begin
                        res_last_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        res_last_d = 1'b0;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                ptr_d   = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; an asynchronous reset abandons any job in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            ptr_q        <= '0;
            flush_cnt_q  <= '0;
            cur_word_q   <= '0;
            cur_valid_q  <= 1'b0;
            next_word_q  <= '0;
            next_valid_q <= 1'b0;
            bit_idx_q    <= '0;
            bits_done_q  <= '0;
            words_q      <= '0;
            blk_cnt_q    <= '0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            res_last_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            ptr_q        <= ptr_d;
            flush_cnt_q  <= flush_cnt_d;
            cur_word_q   <= cur_word_d;
            cur_valid_q  <= cur_valid_d;
            next_word_q  <= next_word_d;
            next_valid_q <= next_valid_d;
            bit_idx_q    <= bit_idx_d;
            bits_done_q  <= bits_done_d;
            words_q      <= words_d;
            blk_cnt_q    <= blk_cnt_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            res_last_q   <= res_last_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule
